// File: rtl/controle_semaforo.sv
// Traffic-light controller: green/amber/red-walk/all-red cycle timed by Temp_15 ticks, with pedestrian early exit.
// Optional night flashing-amber mode compiled in with `define MODO_NOTURNO_EN.
module controle_semaforo #(
    parameter int T_VERDE     = 4,
    parameter int T_AMARELO   = 1,
    parameter int T_VERMELHO  = 3,
    parameter int T_LIMPEZA   = 1,
    parameter int T_VERDE_MIN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Temp_15,
    input  logic       ped_btn,
`ifdef MODO_NOTURNO_EN
    input  logic       noturno,
`endif
    output logic       luz_verde,
    output logic       luz_amarela,
    output logic       luz_vermelha,
    output logic       ped_verde,
    output logic [3:0] ticks_rest,
    output logic       ped_pend
);

    typedef enum logic [2:0] {
        VERDE,
        AMARELO,
        VERMELHO,
        LIMPEZA
`ifdef MODO_NOTURNO_EN
        , PISCA
`endif
    } estado_t;

    estado_t    estado, estado_n;
    logic [3:0] rest_n;
    logic       pend_n;
    logic       verde_n, amarela_n, vermelha_n, ped_verde_n;
    logic [4:0] decorrido;

    function automatic logic [3:0] duracao(input estado_t s);
        case (s)
            VERDE:    duracao = 4'(T_VERDE);
            AMARELO:  duracao = 4'(T_AMARELO);
            VERMELHO: duracao = 4'(T_VERMELHO);
            LIMPEZA:  duracao = 4'(T_LIMPEZA);
            default:  duracao = 4'd0;
        endcase
    endfunction

    function automatic estado_t proximo(input estado_t s);
        case (s)
            VERDE:    proximo = AMARELO;
            AMARELO:  proximo = VERMELHO;
            VERMELHO: proximo = LIMPEZA;
            default:  proximo = VERDE;
        endcase
    endfunction

    // Green ticks already served, counting the one now elapsing; ticks_rest never exceeds T_VERDE in VERDE.
    assign decorrido = 5'(T_VERDE) - {1'b0, ticks_rest} + 5'd1;

    always_comb begin
        estado_n = estado;
        rest_n   = ticks_rest;
        pend_n   = ped_pend;

        if (ped_btn && estado != VERMELHO)
            pend_n = 1'b1;

`ifdef MODO_NOTURNO_EN
        if (estado == PISCA) begin
            if (Temp_15 && !noturno)
                estado_n = LIMPEZA;
        end else
`endif
        if (Temp_15) begin
            if (estado == VERDE && ped_pend && decorrido >= 5'(T_VERDE_MIN))
                estado_n = AMARELO;
            else if (ticks_rest == 4'd1)
                estado_n = proximo(estado);
            else
                rest_n = ticks_rest - 4'd1;
        end

`ifdef MODO_NOTURNO_EN
        if (noturno)
            estado_n = PISCA;
`endif

        if (estado_n != estado) begin
            rest_n = duracao(estado_n);
            if (estado_n == VERMELHO)
                pend_n = 1'b0;
        end

        verde_n     = (estado_n == VERDE);
        amarela_n   = (estado_n == AMARELO);
        vermelha_n  = (estado_n == VERMELHO) || (estado_n == LIMPEZA);
        ped_verde_n = (estado_n == VERMELHO);

`ifdef MODO_NOTURNO_EN
        // Flashing amber starts lit on entry and toggles once per tick while night mode lasts.
        if (estado_n == PISCA) begin
            pend_n = 1'b0;
            if (estado != PISCA)
                amarela_n = 1'b1;
            else if (Temp_15)
                amarela_n = ~luz_amarela;
            else
                amarela_n = luz_amarela;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado       <= LIMPEZA;
            ticks_rest   <= 4'(T_LIMPEZA);
            ped_pend     <= 1'b0;
            luz_verde    <= 1'b0;
            luz_amarela  <= 1'b0;
            luz_vermelha <= 1'b1;
            ped_verde    <= 1'b0;
        end else begin
            estado       <= estado_n;
            ticks_rest   <= rest_n;
            ped_pend     <= pend_n;
            luz_verde    <= verde_n;
            luz_amarela  <= amarela_n;
            luz_vermelha <= vermelha_n;
            ped_verde    <= ped_verde_n;
        end
    end

endmodule

// File: tb/tb_controle_semaforo.sv
// Directed bench for controle_semaforo; night-mode vectors run when MODO_NOTURNO_EN is defined.
module tb_controle_semaforo;

    logic       clk;
    logic       reset;
    logic       Temp_15;
    logic       ped_btn;
`ifdef MODO_NOTURNO_EN
    logic       noturno;
`endif
    logic       luz_verde, luz_amarela, luz_vermelha, ped_verde, ped_pend;
    logic [3:0] ticks_rest;

    int n_total = 0;
    int n_bad   = 0;

    // Lamp groups {verde, amarela, vermelha, ped_verde}
    localparam logic [3:0] L_VD = 4'b1000;
    localparam logic [3:0] L_AM = 4'b0100;
    localparam logic [3:0] L_VM = 4'b0011;
    localparam logic [3:0] L_LP = 4'b0010;
    localparam logic [3:0] L_NO = 4'b0000;

    controle_semaforo dut (
        .clk          (clk),
        .reset        (reset),
        .Temp_15      (Temp_15),
        .ped_btn      (ped_btn),
`ifdef MODO_NOTURNO_EN
        .noturno      (noturno),
`endif
        .luz_verde    (luz_verde),
        .luz_amarela  (luz_amarela),
        .luz_vermelha (luz_vermelha),
        .ped_verde    (ped_verde),
        .ticks_rest   (ticks_rest),
        .ped_pend     (ped_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] status();
        return {luz_verde, luz_amarela, luz_vermelha, ped_verde, ped_pend, ticks_rest};
    endfunction

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic t, input logic p);
        Temp_15 = t;
        ped_btn = p;
        @(posedge clk);
        #1;
        Temp_15 = 1'b0;
        ped_btn = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    // 14 idle clocks followed by the clock carrying the tick: one Temp_15 pulse every 15 clocks.
    task automatic tick();
        idle(14);
        cyc(1'b1, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        Temp_15 = 1'b0;
        ped_btn = 1'b0;
`ifdef MODO_NOTURNO_EN
        noturno = 1'b0;
`endif
        #2 reset = 1'b0;
        #1 check_eq("reset_async", status(), {L_LP, 1'b0, 4'd1});
        repeat (3) @(posedge clk);
        #1 check_eq("reset_hold", status(), {L_LP, 1'b0, 4'd1});
        reset = 1'b1;

        // Plain cycle with default durations
        tick(); check_eq("t1_verde", status(), {L_VD, 1'b0, 4'd4});
        tick(); check_eq("t2_verde", status(), {L_VD, 1'b0, 4'd3});
        tick(); tick(); check_eq("t4_verde", status(), {L_VD, 1'b0, 4'd1});
        tick(); check_eq("t5_amarelo", status(), {L_AM, 1'b0, 4'd1});
        idle(10); check_eq("hold_no_tick", status(), {L_AM, 1'b0, 4'd1});
        idle(4); cyc(1'b1, 1'b0); check_eq("t6_vermelho", status(), {L_VM, 1'b0, 4'd3});
        tick(); tick(); check_eq("t8_vermelho", status(), {L_VM, 1'b0, 4'd1});
        tick(); check_eq("t9_limpeza", status(), {L_LP, 1'b0, 4'd1});
        tick(); check_eq("t10_verde", status(), {L_VD, 1'b0, 4'd4});

        // Press 3 clocks into green shortens it to one tick
        idle(2); cyc(1'b0, 1'b1);
        check_eq("ped_latched", status(), {L_VD, 1'b1, 4'd4});
        idle(11); cyc(1'b1, 1'b0);
        check_eq("ped_early_amarelo", status(), {L_AM, 1'b1, 4'd1});
        tick(); check_eq("ped_clear_vermelho", status(), {L_VM, 1'b0, 4'd3});

        // Presses during red are ignored
        tick(); cyc(1'b0, 1'b1); idle(2); cyc(1'b0, 1'b1);
        check_eq("ped_in_red_ignored", status(), {L_VM, 1'b0, 4'd2});
        idle(10); cyc(1'b1, 1'b0); tick();
        check_eq("after_red_limpeza", status(), {L_LP, 1'b0, 4'd1});
        tick(); tick(); tick(); tick();
        check_eq("full_green_last", status(), {L_VD, 1'b0, 4'd1});
        tick(); check_eq("full_green_amarelo", status(), {L_AM, 1'b0, 4'd1});

        // Press coinciding with a tick only takes effect from the next tick
        tick(); tick(); tick(); tick(); tick();
        check_eq("back_to_verde", status(), {L_VD, 1'b0, 4'd4});
        cyc(1'b1, 1'b1);
        check_eq("press_with_tick", status(), {L_VD, 1'b1, 4'd3});
        tick(); check_eq("press_tick_amarelo", status(), {L_AM, 1'b1, 4'd1});

        // Asynchronous reset between clock edges while amber
        #2 reset = 1'b0;
        #1 check_eq("reset_mid_amarelo", status(), {L_LP, 1'b0, 4'd1});
        @(posedge clk);
        #1 reset = 1'b1;
        tick(); check_eq("after_reset_verde", status(), {L_VD, 1'b0, 4'd4});

        // Held tick counts once per clock
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
        check_eq("held_tick", status(), {L_VD, 1'b0, 4'd2});

`ifdef MODO_NOTURNO_EN
        noturno = 1'b1;
        cyc(1'b0, 1'b0); check_eq("pisca_entry", status(), {L_AM, 1'b0, 4'd0});
        tick(); check_eq("pisca_tick1", status(), {L_NO, 1'b0, 4'd0});
        tick(); check_eq("pisca_tick2", status(), {L_AM, 1'b0, 4'd0});
        cyc(1'b0, 1'b1); check_eq("pisca_ped_ignored", status(), {L_AM, 1'b0, 4'd0});
        noturno = 1'b0;
        cyc(1'b0, 1'b0); check_eq("pisca_wait_tick", status(), {L_AM, 1'b0, 4'd0});
        tick(); check_eq("pisca_exit_limpeza", status(), {L_LP, 1'b0, 4'd1});
        tick(); check_eq("pisca_then_verde", status(), {L_VD, 1'b0, 4'd4});
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/controle_semaforo.md
CONTROLE_SEMAFORO -- requirements
Module: controle_semaforo

Interface
REQ-001 Parameter T_VERDE, default 4, green duration in Temp_15 ticks (1..15).
REQ-002 Parameter T_AMARELO, default 1, amber duration in ticks (1..15).
REQ-003 Parameter T_VERMELHO, default 3, red/pedestrian-walk duration in ticks (1..15).
REQ-004 Parameter T_LIMPEZA, default 1, all-red clearance duration in ticks (1..15).
REQ-005 Parameter T_VERDE_MIN, default 1, minimum green ticks before a pedestrian request shortens green (1..T_VERDE).
REQ-006 clk  input  1  single system clock, all state changes on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-008 Temp_15  input  1  one-clk-wide tick pulse from the 15 s timer stage.
REQ-009 ped_btn  input  1  pedestrian button level, synchronous to clk.
REQ-010 luz_verde, luz_amarela, luz_vermelha  output  1 each  vehicle lamps, registered, exactly one high outside night mode.
REQ-011 ped_verde  output  1  pedestrian walk lamp, registered.
REQ-012 ticks_rest  output  4  ticks remaining in current state, registered.
REQ-013 ped_pend  output  1  latched pending pedestrian request, registered.

Function
REQ-014 States: VERDE, AMARELO, VERMELHO, LIMPEZA; cycle VERDE->AMARELO->VERMELHO->LIMPEZA->VERDE.
REQ-015 Lamps: VERDE verde=1; AMARELO amarela=1; VERMELHO vermelha=1, ped_verde=1; LIMPEZA vermelha=1, ped_verde=0.
REQ-016 On entry to a state ticks_rest loads that state's T_ parameter.
REQ-017 Clock edge with Temp_15=1: if ticks_rest==1, move to next state and load its duration; else ticks_rest decrements by 1.
REQ-018 Clock edge with Temp_15=0: state and ticks_rest hold; no transition happens between ticks.
REQ-019 ped_pend sets at an edge where ped_btn=1 and state is not VERMELHO; clears on entry to VERMELHO; presses during VERMELHO ignored.
REQ-020 Early exit: in VERDE, at a tick edge with registered ped_pend=1 and (T_VERDE - ticks_rest + 1) >= T_VERDE_MIN, move to AMARELO regardless of ticks_rest.
REQ-021 A press in the same cycle as a tick does not cause early exit on that tick; it counts from the next tick.
REQ-022 Lamp outputs change on the same edge as the state change (zero extra latency).
REQ-023 Temp_15 held high multiple cycles counts once per cycle; block does no edge detection.

Reset
REQ-024 reset=0 forces immediately, independent of clk: state LIMPEZA, ticks_rest=T_LIMPEZA, luz_vermelha=1, other lamps 0, ped_verde=0, ped_pend=0.
REQ-025 Reset asserted mid-state aborts that state with no completion; after release, first tick evaluates LIMPEZA per REQ-017.

Configuration
REQ-026 Macro MODO_NOTURNO_EN compiles in input noturno (1 bit) and state PISCA.
REQ-027 With macro: noturno=1 at any edge enters PISCA; verde=vermelha=ped_verde=0, ped_pend=0, ticks_rest=0, luz_amarela toggles on each Temp_15 tick, starting at 1 on entry.
REQ-028 With macro: in PISCA, first tick edge with noturno=0 enters LIMPEZA, loading T_LIMPEZA.
REQ-029 Without macro: no noturno port, no PISCA state, behaviour exactly REQ-014..REQ-025.

Verification
REQ-030 Defaults, Temp_15 every 15 clks, no ped: release reset -> tick1 VERDE rest=4, tick5 AMARELO rest=1, tick6 VERMELHO rest=3 ped_verde=1, tick9 LIMPEZA, tick10 VERDE.
REQ-031 ped_btn 1-clk pulse 3 clks after VERDE entry -> ped_pend=1, next tick AMARELO (green lasts 1 tick), ped_pend clears at VERMELHO entry.
REQ-032 ped_btn and Temp_15 high in same cycle in VERDE (rest=4) -> that tick rest=3 only, next tick AMARELO.
REQ-033 ped_btn pulses during VERMELHO -> ped_pend stays 0, following VERDE lasts full 4 ticks.
REQ-034 reset=0 mid-clock in AMARELO -> same-instant luz_vermelha=1, amarela=0, ticks_rest=1, ped_pend=0.
REQ-035 MODO_NOTURNO_EN defined, noturno=1 in VERDE -> next edge PISCA, amarela 1,0,1 on three ticks; noturno=0 -> next tick LIMPEZA rest=1.
